// File: rtl/sdr_xfer_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sdr_xfer_pkg
// Shared definitions for the SDR transfer controller: FSM state encoding and
// the status codes reported to the HPS after each command.
// ---------------------------------------------------------------------------
package sdr_xfer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_START,
        RD_WAIT,
        XFER,
        WR_START,
        WR_WAIT,
        DONE
    } xfer_state_e;

    localparam logic [7:0] STAT_OK    = 8'd1;
    localparam logic [7:0] STAT_RD_TO = 8'd2;
    localparam logic [7:0] STAT_WR_TO = 8'd3;

endpackage

// File: rtl/sdr_xfer_ctrl_if.sv
// ---------------------------------------------------------------------------
// sdr_xfer_ctrl_if
// Bundle of the SDR bridge signals between the transfer controller (master)
// and the SDR bridge (slave).
//   sdr_baseaddr   master->slave  block base address
//   sdr_nelems     master->slave  element count
//   sdr_readstart  master->slave  one-cycle read request
//   sdr_readend    slave->master  read complete, sdr_readdata valid
//   sdr_readdata   slave->master  read block
//   sdr_writestart master->slave  one-cycle write request
//   sdr_writeend   slave->master  write complete
//   sdr_writedata  master->slave  packed write block
// ---------------------------------------------------------------------------
interface sdr_xfer_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int BUS_W  = 2048
);
    logic [ADDR_W-1:0] sdr_baseaddr;
    logic [29:0]       sdr_nelems;
    logic              sdr_readstart;
    logic              sdr_readend;
    logic [BUS_W-1:0]  sdr_readdata;
    logic              sdr_writestart;
    logic              sdr_writeend;
    logic [BUS_W-1:0]  sdr_writedata;

    modport master (
        output sdr_baseaddr, sdr_nelems, sdr_readstart, sdr_writestart, sdr_writedata,
        input  sdr_readend, sdr_readdata, sdr_writeend
    );

    modport slave (
        input  sdr_baseaddr, sdr_nelems, sdr_readstart, sdr_writestart, sdr_writedata,
        output sdr_readend, sdr_readdata, sdr_writeend
    );
endinterface

// File: rtl/sdr_xfer_ctrl_unpack.sv
// ---------------------------------------------------------------------------
// sdr_wide_unpack
// Holds one wide SDR read block and presents it as a valid/ready word stream.
//   clk, rst_n  clock, asynchronous active-low reset
//   load        capture data_i and restart the word index at 0
//   data_i      wide read block
//   active      stream enable (controller is in its transfer phase)
//   n           number of words to present
//   word/valid/last/ready  output stream
//   drained     index will equal n after this cycle
// ---------------------------------------------------------------------------
module sdr_wide_unpack #(
    parameter int WORD_W = 32,
    parameter int NWORDS = 64,
    parameter int CNT_W  = $clog2(NWORDS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [WORD_W*NWORDS-1:0] data_i,
    input  logic                     active,
    input  logic [CNT_W-1:0]         n,
    output logic [WORD_W-1:0]        word,
    output logic                     valid,
    output logic                     last,
    input  logic                     ready,
    output logic                     drained
);
    localparam int BUS_W = WORD_W * NWORDS;

    logic [BUS_W-1:0] rbuf_q;
    logic [CNT_W-1:0] idx_q, idx_d;

    always_comb begin
        valid = active && (idx_q < n);
        last  = valid && (idx_q == n - CNT_W'(1));
        word  = '0;
        if (valid) begin
            word = rbuf_q[int'(idx_q) * WORD_W +: WORD_W];
        end
    end

    always_comb begin
        idx_d = idx_q;
        if (load) begin
            idx_d = '0;
        end else if (valid && ready) begin
            idx_d = idx_q + CNT_W'(1);
        end
    end

    // Look-ahead so the controller can leave the stream phase the cycle
    // after the final handshake rather than one cycle later.
    assign drained = (idx_d == n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbuf_q <= '0;
            idx_q  <= '0;
        end else begin
            idx_q <= idx_d;
            if (load) begin
                rbuf_q <= data_i;
            end
        end
    end

endmodule

// File: rtl/sdr_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// sdr_xfer_ctrl
// Transfer controller between the ray-tracing core and the SDR bridge. Each
// command reads one block of up to NWORDS words, streams it out word by word,
// optionally collects an equal-length result stream, packs it and writes it
// back. Waits on the bridge are bounded by TIMEOUT cycles.
//   sdr_clk, sdr_reset_n      clock, asynchronous active-low reset
//   start, cmd_*              command strobe and fields (sampled in IDLE)
//   sdr                       SDR bridge bundle (master side)
//   rd_word/valid/last/ready  unpacked read stream
//   wr_word/valid/ready       result stream
//   busy, done, status        controller status for the HPS
// ---------------------------------------------------------------------------
module sdr_xfer_ctrl
    import sdr_xfer_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int NWORDS  = 64,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1_000_000,
    parameter int CNT_W   = $clog2(NWORDS + 1)
) (
    input  logic              sdr_clk,
    input  logic              sdr_reset_n,

    input  logic              start,
    input  logic [ADDR_W-1:0] cmd_rdaddr,
    input  logic [ADDR_W-1:0] cmd_wraddr,
    input  logic [CNT_W-1:0]  cmd_nelems,
    input  logic              cmd_wb,

    sdr_xfer_ctrl_if.master   sdr,

    output logic [WORD_W-1:0] rd_word,
    output logic              rd_valid,
    output logic              rd_last,
    input  logic              rd_ready,

    input  logic [WORD_W-1:0] wr_word,
    input  logic              wr_valid,
    output logic              wr_ready,

    output logic              busy,
    output logic              done,
    output logic [7:0]        status
);
    localparam int BUS_W = WORD_W * NWORDS;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    xfer_state_e       state_q, state_d;
    logic [ADDR_W-1:0] rdaddr_q, wraddr_q;
    logic [CNT_W-1:0]  n_q, n_clamp;
    logic              wb_q;
    logic [CNT_W-1:0]  wi_q, wi_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [BUS_W-1:0]  wbuf_q;
    logic [7:0]        status_q, status_d;

    logic accept;
    logic rd_load;
    logic rd_drained;

    assign n_clamp = (cmd_nelems > CNT_W'(NWORDS)) ? CNT_W'(NWORDS) : cmd_nelems;
    assign accept  = (state_q == IDLE) && start;
    assign rd_load = (state_q == RD_WAIT) && sdr.sdr_readend;

    sdr_wide_unpack #(
        .WORD_W (WORD_W),
        .NWORDS (NWORDS),
        .CNT_W  (CNT_W)
    ) u_unpack (
        .clk     (sdr_clk),
        .rst_n   (sdr_reset_n),
        .load    (rd_load),
        .data_i  (sdr.sdr_readdata),
        .active  (state_q == XFER),
        .n       (n_q),
        .word    (rd_word),
        .valid   (rd_valid),
        .last    (rd_last),
        .ready   (rd_ready),
        .drained (rd_drained)
    );

    // Result stream intake.
    assign wr_ready = (state_q == XFER) && wb_q && (wi_q < n_q);

    always_comb begin
        wi_d = wi_q;
        if (accept) begin
            wi_d = '0;
        end else if (wr_ready && wr_valid) begin
            wi_d = wi_q + CNT_W'(1);
        end
    end

    // FSM next-state and strobes.
    always_comb begin
        state_d            = state_q;
        status_d           = status_q;
        to_d               = to_q;
        sdr.sdr_readstart  = 1'b0;
        sdr.sdr_writestart = 1'b0;
        done               = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (n_clamp == '0) begin
                        state_d  = DONE;
                        status_d = STAT_OK;
                    end else begin
                        state_d = RD_START;
                    end
                end
            end
            RD_START: begin
                sdr.sdr_readstart = 1'b1;
                to_d              = '0;
                state_d           = RD_WAIT;
            end
            RD_WAIT: begin
                to_d = to_q + TO_W'(1);
                if (sdr.sdr_readend) begin
                    state_d = XFER;
                end else if (to_q == TO_LAST) begin
                    state_d  = DONE;
                    status_d = STAT_RD_TO;
                end
            end
            XFER: begin
                // Next-cycle counts, so exit follows the final handshake directly.
                if (rd_drained && (!wb_q || (wi_d == n_q))) begin
                    if (wb_q) begin
                        state_d = WR_START;
                    end else begin
                        state_d  = DONE;
                        status_d = STAT_OK;
                    end
                end
            end
            WR_START: begin
                sdr.sdr_writestart = 1'b1;
                to_d               = '0;
                state_d            = WR_WAIT;
            end
            WR_WAIT: begin
                to_d = to_q + TO_W'(1);
                if (sdr.sdr_writeend) begin
                    state_d  = DONE;
                    status_d = STAT_OK;
                end else if (to_q == TO_LAST) begin
                    state_d  = DONE;
                    status_d = STAT_WR_TO;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sdr_clk or negedge sdr_reset_n) begin
        if (!sdr_reset_n) begin
            state_q  <= IDLE;
            status_q <= '0;
            to_q     <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            to_q     <= to_d;
        end
    end

    // Command latch and write pack buffer.
    always_ff @(posedge sdr_clk or negedge sdr_reset_n) begin
        if (!sdr_reset_n) begin
            rdaddr_q <= '0;
            wraddr_q <= '0;
            n_q      <= '0;
            wb_q     <= 1'b0;
            wi_q     <= '0;
            wbuf_q   <= '0;
        end else begin
            wi_q <= wi_d;
            if (accept) begin
                rdaddr_q <= cmd_rdaddr;
                wraddr_q <= cmd_wraddr;
                n_q      <= n_clamp;
                wb_q     <= cmd_wb;
                wbuf_q   <= '0;
            end else if (wr_ready && wr_valid) begin
                wbuf_q[int'(wi_q) * WORD_W +: WORD_W] <= wr_word;
            end
        end
    end

    always_comb begin
        sdr.sdr_baseaddr = '0;
        sdr.sdr_nelems   = '0;
        case (state_q)
            RD_START, RD_WAIT: begin
                sdr.sdr_baseaddr = rdaddr_q;
                sdr.sdr_nelems   = 30'(n_q);
            end
            WR_START, WR_WAIT: begin
                sdr.sdr_baseaddr = wraddr_q;
                sdr.sdr_nelems   = 30'(n_q);
            end
            default: ;
        endcase
    end

    assign sdr.sdr_writedata = wbuf_q;
    assign busy              = (state_q != IDLE);
    assign status            = status_q;

endmodule

// File: tb/tb_sdr_xfer_ctrl.sv
module tb_sdr_xfer_ctrl;
    localparam int WW = 32;
    localparam int NW = 64;
    localparam int TO = 16;
    localparam int BW = WW * NW;

    logic          sdr_clk = 1'b0;
    logic          sdr_reset_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   cmd_rdaddr = '0, cmd_wraddr = '0;
    logic [6:0]    cmd_nelems = '0;
    logic          cmd_wb = 1'b0;
    logic [WW-1:0] rd_word;
    logic          rd_valid, rd_last;
    logic          rd_ready = 1'b0;
    logic [WW-1:0] wr_word = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready, busy, done;
    logic [7:0]    status;

    sdr_xfer_ctrl_if #(.ADDR_W(32), .BUS_W(BW)) bus ();

    sdr_xfer_ctrl #(
        .WORD_W(WW), .NWORDS(NW), .ADDR_W(32), .TIMEOUT(TO)
    ) dut (
        .sdr_clk(sdr_clk), .sdr_reset_n(sdr_reset_n),
        .start(start), .cmd_rdaddr(cmd_rdaddr), .cmd_wraddr(cmd_wraddr),
        .cmd_nelems(cmd_nelems), .cmd_wb(cmd_wb),
        .sdr(bus),
        .rd_word(rd_word), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
        .wr_word(wr_word), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .busy(busy), .done(done), .status(status)
    );

    always #5 sdr_clk = ~sdr_clk;

    int cyc = 0;
    always @(posedge sdr_clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Command model (owned by the driver).
    logic [31:0] mdl_block [NW];
    int          mdl_n;
    bit          mdl_wb;
    logic [31:0] mdl_rdaddr, mdl_wraddr;
    logic [7:0]  mdl_status;
    int          starts_acc = 0;
    int          aborts = 0;
    int          t0;

    // Scoreboard state (owned by the compare process).
    int          seen_cmd = 0;
    int          dones = 0;
    int          mdl_ri, mdl_wi;
    logic [31:0] mdl_wbuf [NW];
    int          rs_cnt, ws_cnt, rs_cyc, ws_cyc, re_cyc, fv_cyc, last_rhs, last_whs, done_cyc;
    bit          prev_ws;
    logic [31:0] last_word, cap_wait_addr;
    logic [BW-1:0] cap_wdata;

    always @(negedge sdr_clk) begin
        if (sdr_reset_n) begin
            if (starts_acc != seen_cmd) begin
                seen_cmd = starts_acc;
                mdl_ri = 0; mdl_wi = 0;
                for (int i = 0; i < NW; i++) mdl_wbuf[i] = '0;
                rs_cnt = 0; ws_cnt = 0; rs_cyc = -1; ws_cyc = -1; re_cyc = -1;
                fv_cyc = -1; last_rhs = -1; last_whs = -1; done_cyc = -1;
                prev_ws = 0; last_word = '0; cap_wait_addr = '0;
            end
            chk("busy", busy, (starts_acc > dones + aborts));
            if (!(starts_acc > dones + aborts)) begin
                chk("idle_outs", {bus.sdr_readstart, bus.sdr_writestart, rd_valid, wr_ready,
                                  done, bus.sdr_baseaddr != 0, bus.sdr_nelems != 0}, 0);
            end else begin
                if (rd_valid) begin
                    if (fv_cyc < 0) fv_cyc = cyc;
                    chk("rd_in_range", mdl_ri < mdl_n, 1);
                    if (mdl_ri < NW) begin
                        chk("rd_word", rd_word, mdl_block[mdl_ri]);
                        chk("rd_last", rd_last, mdl_ri == mdl_n - 1);
                    end
                    if (rd_ready) begin
                        if (rd_last) last_word = rd_word;
                        mdl_ri++;
                        last_rhs = cyc;
                    end
                end
                if (wr_ready) begin
                    chk("wr_ready_allowed", mdl_wb && (mdl_wi < mdl_n), 1);
                    if (wr_valid && mdl_wi < NW) begin
                        mdl_wbuf[mdl_wi] = wr_word;
                        mdl_wi++;
                        last_whs = cyc;
                    end
                end
                if (bus.sdr_readstart) begin
                    rs_cnt++; rs_cyc = cyc;
                    chk("rd_addr", bus.sdr_baseaddr, mdl_rdaddr);
                    chk("rd_nelems", bus.sdr_nelems, mdl_n);
                end
                if (bus.sdr_readend && re_cyc < 0 && rs_cyc >= 0) re_cyc = cyc;
                if (prev_ws) cap_wait_addr = bus.sdr_baseaddr;
                prev_ws = bus.sdr_writestart;
                if (bus.sdr_writestart) begin
                    ws_cnt++; ws_cyc = cyc;
                    cap_wdata = bus.sdr_writedata;
                    chk("ws_after_streams", (mdl_ri == mdl_n) && (mdl_wi == mdl_n), 1);
                    chk("wr_addr", bus.sdr_baseaddr, mdl_wraddr);
                    chk("wr_nelems", bus.sdr_nelems, mdl_n);
                    for (int i = 0; i < NW; i++)
                        chk("wdata_word", bus.sdr_writedata[i*WW +: WW], mdl_wbuf[i]);
                end
                if (done) begin
                    dones++; done_cyc = cyc;
                    chk("status", status, mdl_status);
                    if (mdl_status == 8'd1) begin
                        chk("rd_count", mdl_ri, mdl_n);
                        if (mdl_wb) chk("wr_count", mdl_wi, mdl_n);
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        start = 0; rd_ready = 0; wr_valid = 0;
        bus.sdr_readend = 0; bus.sdr_writeend = 0;
    endtask

    task automatic run_cmd(input logic [31:0] ra, input logic [31:0] wa, input int nel,
                           input bit wb, input logic [31:0] base, input int rdy_pct,
                           input int wv_pct, input bit rd_resp, input bit wr_resp,
                           input bit poke_start, input int reset_at);
        logic [BW-1:0] blk;
        int  re_at, we_at, drv_wi, bud;
        bit  fin, poked, saw_valid, rst_hit;
        mdl_n = (nel > NW) ? NW : nel;
        mdl_wb = wb; mdl_rdaddr = ra; mdl_wraddr = wa;
        for (int i = 0; i < NW; i++) begin
            mdl_block[i] = (base != 0) ? base + 32'(i) : $urandom;
            blk[i*WW +: WW] = mdl_block[i];
        end
        mdl_status = (mdl_n == 0) ? 8'd1 : !rd_resp ? 8'd2 : (wb && !wr_resp) ? 8'd3 : 8'd1;

        @(posedge sdr_clk); #1;
        start = 1; cmd_rdaddr = ra; cmd_wraddr = wa; cmd_nelems = 7'(nel); cmd_wb = wb;
        t0 = cyc;
        @(posedge sdr_clk); #1;
        start = 0; starts_acc++;
        cmd_rdaddr = $urandom; cmd_wraddr = $urandom; cmd_nelems = 7'($urandom); cmd_wb = 1'($urandom);
        re_at = -1; we_at = -1; drv_wi = 0; bud = 0;
        fin = 0; poked = 0; saw_valid = 0; rst_hit = 0;
        while (!fin && !rst_hit && bud < 3000) begin
            bud++;
            start = 0;
            if (reset_at > 0 && mdl_ri >= reset_at) begin
                sdr_reset_n = 0; aborts++;
                #1;
                chk("rst_outs", {rd_valid, rd_last, busy, done, wr_ready,
                                 bus.sdr_readstart, bus.sdr_writestart}, 0);
                chk("rst_rd_word", rd_word, 0);
                chk("rst_status", status, 0);
                chk("rst_addr", {bus.sdr_baseaddr, bus.sdr_nelems != 0}, 0);
                chk("rst_wdata", |bus.sdr_writedata, 0);
                idle_inputs();
                repeat (2) @(posedge sdr_clk);
                #1 sdr_reset_n = 1;
                rst_hit = 1;
            end else begin
                bus.sdr_readend = (cyc == re_at);
                bus.sdr_readdata = (cyc == re_at) ? blk : {NW{$urandom}};
                bus.sdr_writeend = (cyc == we_at);
                rd_ready = ($urandom_range(0, 99) < rdy_pct);
                wr_valid = (drv_wi < mdl_n) && ($urandom_range(0, 99) < wv_pct);
                wr_word = (drv_wi < NW) ? (mdl_block[drv_wi] ^ 32'hFFFF_FFFF) : $urandom;
                if (poke_start && saw_valid && !poked) begin
                    start = 1; cmd_nelems = '0; poked = 1;
                end
                @(negedge sdr_clk);
                if (bus.sdr_readstart && rd_resp) re_at = cyc + 1 + $urandom_range(0, 3);
                if (bus.sdr_writestart && wr_resp) we_at = cyc + 1 + $urandom_range(0, 3);
                if (wr_valid && wr_ready) drv_wi++;
                if (rd_valid) saw_valid = 1;
                if (done) fin = 1;
                @(posedge sdr_clk); #1;
            end
        end
        idle_inputs();
        if (!rst_hit) begin
            chk("cmd_completes", fin, 1);
            chk("rs_pulses", rs_cnt, (mdl_n == 0) ? 0 : 1);
            chk("ws_pulses", ws_cnt, (wb && rd_resp && mdl_n > 0) ? 1 : 0);
            if (mdl_n == 0) begin
                chk("n0_done_cyc", done_cyc - t0, 1);
            end else begin
                chk("rs_cyc", rs_cyc - t0, 1);
                if (!rd_resp) begin
                    chk("rd_to_cyc", done_cyc - t0, 2 + TO);
                end else begin
                    chk("first_valid_cyc", fv_cyc - re_cyc, 1);
                    if (!wb) begin
                        chk("ro_done_cyc", done_cyc - last_rhs, 1);
                    end else begin
                        chk("ws_cyc", ws_cyc - ((last_rhs > last_whs) ? last_rhs : last_whs), 1);
                        if (!wr_resp) chk("wr_to_cyc", done_cyc - ws_cyc, 1 + TO);
                        else          chk("wr_done_cyc", done_cyc - we_at, 1);
                    end
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        bus.sdr_readdata = '0;
        repeat (3) @(posedge sdr_clk);
        #1;
        chk("reset_outs", {rd_valid, rd_last, busy, done, wr_ready,
                           bus.sdr_readstart, bus.sdr_writestart}, 0);
        chk("reset_status", status, 0);
        chk("reset_wdata", |bus.sdr_writedata, 0);
        sdr_reset_n = 1;
        repeat (2) @(posedge sdr_clk);

        // Read-only, 15 words, incrementing pattern, always ready.
        run_cmd(32'h0, 32'h0, 15, 0, 32'hA000_0000, 100, 0, 1, 1, 0, 0);
        chk("t1_nwords", mdl_ri, 15);
        chk("t1_last_word", last_word, 32'hA000_000E);
        chk("t1_status", status, 8'd1);

        // Read/write-back with stalls, inverted results.
        run_cmd(32'h40, 32'h100, 4, 1, 32'hB000_0000, 50, 50, 1, 1, 0, 0);
        chk("t2_wd0", cap_wdata[31:0], 32'h4FFF_FFFF);
        chk("t2_wd3", cap_wdata[127:96], 32'h4FFF_FFFC);
        chk("t2_upper_zero", |cap_wdata[BW-1:128], 0);
        chk("t2_wait_addr", cap_wait_addr, 32'h100);
        chk("t2_status", status, 8'd1);

        // Zero-length and clamped commands.
        run_cmd(32'h80, 32'h0, 0, 0, 32'h0, 100, 0, 1, 1, 0, 0);
        chk("t3_n0_rs", rs_cnt, 0);
        run_cmd(32'h200, 32'h0, 100, 0, 32'h0, 80, 0, 1, 1, 0, 0);
        chk("t3_clamp_words", mdl_ri, 64);

        // Read timeout, then a normal command.
        run_cmd(32'h300, 32'h0, 8, 0, 32'h0, 100, 0, 0, 1, 0, 0);
        chk("t4_status", status, 8'd2);
        chk("t4_done_after", done_cyc - t0, 18);
        run_cmd(32'h304, 32'h0, 8, 0, 32'h0, 100, 0, 1, 1, 0, 0);
        chk("t4_recover", status, 8'd1);

        // Write timeout.
        run_cmd(32'h400, 32'h500, 6, 1, 32'h0, 100, 100, 1, 0, 0, 0);
        chk("t4w_status", status, 8'd3);

        // start during XFER is ignored; readend in IDLE is ignored.
        run_cmd(32'h600, 32'h0, 10, 0, 32'h0, 40, 0, 1, 1, 1, 0);
        chk("t5_rs", rs_cnt, 1);
        @(posedge sdr_clk); #1;
        bus.sdr_readend = 1; bus.sdr_readdata = {NW{$urandom}};
        @(posedge sdr_clk); #1;
        bus.sdr_readend = 0;
        repeat (3) @(posedge sdr_clk);
        #1 chk("t5_idle_busy", busy, 0);

        // Reset mid-XFER, then a normal write-back command.
        run_cmd(32'h700, 32'h0, 20, 0, 32'h0, 60, 0, 1, 1, 0, 5);
        run_cmd(32'h800, 32'h900, 12, 1, 32'h0, 70, 70, 1, 1, 0, 0);
        chk("t6_after_reset", status, 8'd1);

        // Randomized commands.
        for (int k = 0; k < 8; k++) begin
            run_cmd($urandom, $urandom, $urandom_range(1, 70), 1'($urandom), 32'h0,
                    $urandom_range(30, 100), $urandom_range(30, 100), 1, 1, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
